// File: rtl/dr_ald_16bit_pipe.sv
// dr_ald_16bit_pipe: 3-stage Mitchell log-subtraction approximate divider, Q16.8 quotient.
// Define DR_ALD_ROUND_EN to round right-shifted quotients half-up instead of truncating.
module dr_ald_16bit_pipe #(
  parameter int TRUNC_WIDTH = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [23:0] o_q,
  output logic        o_dz
);
  localparam int TW = TRUNC_WIDTH;

  function automatic logic [3:0] lead_one(input logic [15:0] v);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) k = 4'(i);
    end
    return k;
  endfunction

  // Keeps the top TW-1 mantissa bits below the leading one and forces the LSB high.
  function automatic logic [TW-1:0] trunc_frac(input logic [15:0] v, input logic [3:0] k);
    logic [15:0] aligned;
    aligned = v << (4'd15 - k);
    return TW'({aligned >> (16 - TW), 1'b1});
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [3:0]    s1_k1_q, s1_k1_d, s1_k2_q, s1_k2_d;
  logic [TW-1:0] s1_xt1_q, s1_xt1_d, s1_xt2_q, s1_xt2_d;
  logic          s1_az_q, s1_az_d, s1_bz_q, s1_bz_d;

  logic               s2_valid_q, s2_valid_d;
  logic [TW:0]        s2_m_q, s2_m_d;
  logic signed [6:0]  s2_shift_q, s2_shift_d;
  logic               s2_az_q, s2_az_d, s2_bz_q, s2_bz_d;

  logic        s3_valid_q, s3_valid_d;
  logic [23:0] s3_quo_q, s3_quo_d;
  logic        s3_dz_q, s3_dz_d;

  logic s1_free, s2_free, s3_free;
  logic [TW:0]  diff;
  logic [23:0]  m24, quo;
  logic [4:0]   rsh;

  assign s3_free = !s3_valid_q || i_ready;
  assign s2_free = !s2_valid_q || s3_free;
  assign s1_free = !s1_valid_q || s2_free;
  assign o_ready = s1_free;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_k1_d    = s1_k1_q;
    s1_k2_d    = s1_k2_q;
    s1_xt1_d   = s1_xt1_q;
    s1_xt2_d   = s1_xt2_q;
    s1_az_d    = s1_az_q;
    s1_bz_d    = s1_bz_q;
    if (s1_free) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_k1_d  = lead_one(i_a);
        s1_k2_d  = lead_one(i_b);
        s1_xt1_d = trunc_frac(i_a, lead_one(i_a));
        s1_xt2_d = trunc_frac(i_b, lead_one(i_b));
        s1_az_d  = (i_a == 16'd0);
        s1_bz_d  = (i_b == 16'd0);
      end
    end
  end

  // A borrow out of the mantissa subtraction moves one unit from the exponent.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_m_d     = s2_m_q;
    s2_shift_d = s2_shift_q;
    s2_az_d    = s2_az_q;
    s2_bz_d    = s2_bz_q;
    diff       = {1'b0, s1_xt1_q} - {1'b0, s1_xt2_q};
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_m_d     = {1'b1, diff[TW-1:0]};
        s2_shift_d = 7'(s1_k1_q) - 7'(s1_k2_q) - 7'(diff[TW]) + 7'(8 - TW);
        s2_az_d    = s1_az_q;
        s2_bz_d    = s1_bz_q;
      end
    end
  end

  always_comb begin
    m24 = 24'(s2_m_q);
    rsh = 5'(-s2_shift_q);
    if (!s2_shift_q[6]) begin
      quo = m24 << s2_shift_q[4:0];
    end else begin
      quo = m24 >> rsh;
`ifdef DR_ALD_ROUND_EN
      quo = quo + ((m24 >> (rsh - 5'd1)) & 24'd1);
`else
`endif
    end
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_quo_d   = s3_quo_q;
    s3_dz_d    = s3_dz_q;
    if (s3_free) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        if (s2_bz_q) begin
          s3_quo_d = 24'hFFFFFF;
          s3_dz_d  = 1'b1;
        end else if (s2_az_q) begin
          s3_quo_d = 24'd0;
          s3_dz_d  = 1'b0;
        end else begin
          s3_quo_d = quo;
          s3_dz_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_k1_q    <= '0;
      s1_k2_q    <= '0;
      s1_xt1_q   <= '0;
      s1_xt2_q   <= '0;
      s1_az_q    <= 1'b0;
      s1_bz_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_m_q     <= '0;
      s2_shift_q <= '0;
      s2_az_q    <= 1'b0;
      s2_bz_q    <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_quo_q   <= '0;
      s3_dz_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_k1_q    <= s1_k1_d;
      s1_k2_q    <= s1_k2_d;
      s1_xt1_q   <= s1_xt1_d;
      s1_xt2_q   <= s1_xt2_d;
      s1_az_q    <= s1_az_d;
      s1_bz_q    <= s1_bz_d;
      s2_valid_q <= s2_valid_d;
      s2_m_q     <= s2_m_d;
      s2_shift_q <= s2_shift_d;
      s2_az_q    <= s2_az_d;
      s2_bz_q    <= s2_bz_d;
      s3_valid_q <= s3_valid_d;
      s3_quo_q   <= s3_quo_d;
      s3_dz_q    <= s3_dz_d;
    end
  end

  assign o_valid = s3_valid_q;
  assign o_q     = s3_quo_q;
  assign o_dz    = s3_dz_q;

endmodule
